matmul_tile_pingpong_buf: RTL and testbench
===========================================

# matmul_tile_pingpong_buf

Double-buffered tile buffer between the first (8-bit output) and second (32-bit output) matrix-multiplier stages. Stage 1 streams result rows into one bank while stage 2 drains the other bank. Each tile can optionally be replayed a programmable number of times before its bank is released. Replaces the single fill-then-drain row array with a parametrised, flow-controlled, continuously reusable structure.

## Interface
- DATA_WIDTH, 64, width of one row (MAC_NUM × stage-1 OUTPUT_WIDTH)
- DEPTH, 8, rows per tile; power of two, ≥2
- REP_W, 2, width of replay count
- (derived) ADDR_W = $clog2(DEPTH)

- clk_i  in  1  clock; all logic on rising edge
- rstn_i  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous flush of pointers, flags and replay state
- wr_valid_i  in  1  write row present
- wr_data_i  in  DATA_WIDTH  write row (stage-1 matmul_o)
- wr_ready_o  out  1  current write bank can accept
- rd_repeat_i  in  REP_W  extra passes per tile (0 = read once)
- rd_valid_o  out  1  current read bank holds a complete tile
- rd_ready_i  in  1  consumer accepts row
- rd_data_o  out  DATA_WIDTH  row at read pointer; forced 0 when rd_valid_o=0
- rd_last_o  out  1  rd_valid_o and final row of final pass
- bank_full_o  out  2  full flag per bank
- tile_done_o  out  1  one-cycle pulse after a bank is released
- overflow_o  out  1  sticky: wr_valid_i while wr_ready_o=0

## Operation
- Storage: 2 × DEPTH × DATA_WIDTH, distributed RAM, asynchronous read, not reset (contents undefined after reset).
- State: wr_bank, wr_idx[ADDR_W]; rd_bank, rd_idx[ADDR_W]; full[1:0]; pass_cnt[REP_W]; rep_lat[REP_W].
- wr_ready_o = !full[wr_bank]. Write handshake (wr_valid_i & wr_ready_o): mem[wr_bank][wr_idx] <= wr_data_i; wr_idx++. On wr_idx==DEPTH-1: full[wr_bank] <= 1, wr_bank toggles, wr_idx <= 0.
- rd_valid_o = full[rd_bank]; rd_data_o = mem[rd_bank][rd_idx].
- Read handshake (rd_valid_o & rd_ready_i): rd_idx++. On the first beat of a tile (rd_idx==0, pass_cnt==0), rep_lat <= rd_repeat_i. The value used for the whole tile is the one sampled on that beat.
- On rd_idx==DEPTH-1:
  - If pass_cnt < rep_lat (use rd_repeat_i on a single-beat path when rd_idx==0 coincides): pass_cnt++, rd_idx <= 0, bank kept.
  - Else: full[rd_bank] <= 0, rd_bank toggles, pass_cnt <= 0, rd_idx <= 0, tile_done_o pulses next cycle.
- Simultaneous fill of one bank and release of the other in the same cycle: both updates take effect.
- Writer can never target the bank being read: full flags are registered, so the bank released in cycle N is writable from N+1.
- Overflow: wr_valid_i & !wr_ready_o sets overflow_o. The row is dropped and no pointer moves. Cleared only by reset or clear_i.
- clear_i has priority over both handshakes. It zeroes wr/rd banks and indices, full, pass_cnt, rep_lat, overflow_o and tile_done_o. Memory is untouched.

## Timing
- Reset values: wr_ready_o=1, rd_valid_o=0, rd_data_o=0, rd_last_o=0, bank_full_o=2'b00, tile_done_o=0, overflow_o=0.
- Fill-to-read latency: last-row write handshake at cycle N gives rd_valid_o=1 at N+1 (empty buffer).
- Sustained throughput is 1 row/cycle on each side. With both banks full, wr_ready_o=0 until the cycle after a release.
- tile_done_o is high for exactly one cycle, at N+1 after the releasing beat at N.
- Reset asserted mid-tile: all state returns to reset values immediately (asynchronously). Partial tiles are discarded.

## Test plan
- Single tile, DEPTH=8, rd_repeat_i=0: write rows 0x..01–0x..08 back-to-back, rd_ready_i=1. Required: rd_valid_o rises the cycle after the 8th write; reads return 0x01..0x08 in order; rd_last_o on 0x08; tile_done_o pulses once; bank_full_o returns to 00.
- Ping-pong streaming: 4 tiles written continuously, rd_ready_i=1. Required: wr_ready_o never drops; tiles read in order; 4 tile_done_o pulses; no overflow.
- Back-pressure: rd_ready_i=0, write 17 rows. Required: wr_ready_o=0 after row 16; overflow_o=1; row 17 dropped. Then raise rd_ready_i: 16 rows read unaltered.
- Replay: rd_repeat_i=2 on the first beat, changed to 0 mid-tile. Required: the tile is read 3 times (24 beats); rd_last_o only on beat 24; a single tile_done_o.
- clear_i asserted mid-fill (row 5 of bank 0) together with wr_valid_i. Required: next cycle bank_full_o=00, overflow_o=0; the next 8 writes form a fresh tile starting at row 0.
- rstn_i pulsed low while bank 1 is mid-drain. Required: all outputs take their reset values asynchronously; after release, normal fill and drain resume.

Source files
------------

// File: rtl/matmul_tile_pingpong_buf.sv
// rtl/matmul_tile_pingpong_buf.sv - double-buffered row tile buffer between matmul stages
// Stage 1 fills one bank while stage 2 drains (and optionally replays) the other.
module matmul_tile_pingpong_buf #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int REP_W      = 2,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clear_i,
  input  logic                  wr_valid_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_ready_o,
  input  logic [REP_W-1:0]      rd_repeat_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_last_o,
  output logic [1:0]            bank_full_o,
  output logic                  tile_done_o,
  output logic                  overflow_o
);

  logic [DATA_WIDTH-1:0] mem [2][DEPTH];

  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic [1:0]        full_q, full_d;
  logic [REP_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [REP_W-1:0]  rep_lat_q, rep_lat_d;
  logic              overflow_q, overflow_d;
  logic              tile_done_q, tile_done_d;

  logic              wr_fire, rd_fire, first_beat, rd_end, final_pass, release_w;
  logic [REP_W-1:0]  eff_rep;

  assign wr_ready_o  = !full_q[wr_bank_q];
  assign rd_valid_o  = full_q[rd_bank_q];
  assign rd_data_o   = rd_valid_o ? mem[rd_bank_q][rd_idx_q] : '0;
  assign bank_full_o = full_q;
  assign tile_done_o = tile_done_q;
  assign overflow_o  = overflow_q;

  // The replay count of a tile is fixed by the value seen on its very first beat.
  assign first_beat = (rd_idx_q == '0) && (pass_cnt_q == '0);
  assign eff_rep    = first_beat ? rd_repeat_i : rep_lat_q;
  assign rd_end     = (rd_idx_q == ADDR_W'(DEPTH - 1));
  assign final_pass = !(pass_cnt_q < eff_rep);
  assign rd_last_o  = rd_valid_o && rd_end && final_pass;

  assign wr_fire   = wr_valid_i && wr_ready_o;
  assign rd_fire   = rd_valid_o && rd_ready_i;
  assign release_w = rd_fire && rd_end && final_pass;

  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    rd_bank_d   = rd_bank_q;
    rd_idx_d    = rd_idx_q;
    full_d      = full_q;
    pass_cnt_d  = pass_cnt_q;
    rep_lat_d   = rep_lat_q;
    overflow_d  = overflow_q;
    tile_done_d = release_w;

    if (wr_fire) begin
      wr_idx_d = wr_idx_q + ADDR_W'(1);
      if (wr_idx_q == ADDR_W'(DEPTH - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_idx_d          = '0;
      end
    end
    if (wr_valid_i && !wr_ready_o) begin
      overflow_d = 1'b1;
    end

    // Writer and reader always address different banks, so both full updates can coexist.
    if (rd_fire) begin
      rd_idx_d = rd_idx_q + ADDR_W'(1);
      if (first_beat) begin
        rep_lat_d = rd_repeat_i;
      end
      if (rd_end) begin
        rd_idx_d = '0;
        if (!final_pass) begin
          pass_cnt_d = pass_cnt_q + REP_W'(1);
        end else begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = !rd_bank_q;
          pass_cnt_d        = '0;
        end
      end
    end

    if (clear_i) begin
      wr_bank_d   = 1'b0;
      wr_idx_d    = '0;
      rd_bank_d   = 1'b0;
      rd_idx_d    = '0;
      full_d      = '0;
      pass_cnt_d  = '0;
      rep_lat_d   = '0;
      overflow_d  = 1'b0;
      tile_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      full_q      <= '0;
      pass_cnt_q  <= '0;
      rep_lat_q   <= '0;
      overflow_q  <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      full_q      <= full_d;
      pass_cnt_q  <= pass_cnt_d;
      rep_lat_q   <= rep_lat_d;
      overflow_q  <= overflow_d;
      tile_done_q <= tile_done_d;
    end
  end

  // Row storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_fire && !clear_i) begin
      mem[wr_bank_q][wr_idx_q] <= wr_data_i;
    end
  end

endmodule

// File: tb/tb_matmul_tile_pingpong_buf.sv
// tb/tb_matmul_tile_pingpong_buf.sv - scoreboard bench for matmul_tile_pingpong_buf
// Inputs change 1ns after rising edges; the monitor compares on falling edges.
module tb_matmul_tile_pingpong_buf;

  localparam int DW = 64;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          clear = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic [1:0]    rd_repeat = 2'd0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic [1:0]    bank_full;
  logic          tile_done;
  logic          overflow;

  int checks = 0;
  int failures = 0;

  matmul_tile_pingpong_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .REP_W(2)) dut (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clear),
    .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .rd_repeat_i(rd_repeat), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .rd_data_o(rd_data), .rd_last_o(rd_last), .bank_full_o(bank_full),
    .tile_done_o(tile_done), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Reference model: complete tiles queued as a flat list of rows, oldest first.
  logic [DW-1:0] rows[$];
  logic [DW-1:0] part[$];
  int   ridx, pass, rep_l, rbank;
  logic ovf_m, done_m;
  int   done_cnt, beat_cnt, last_cnt;

  task automatic model_reset();
    rows.delete();
    part.delete();
    ridx = 0; pass = 0; rep_l = 0; rbank = 0;
    ovf_m = 1'b0; done_m = 1'b0;
  endtask

  initial begin : monitor
    int nt, erep;
    logic ev, el, first, rel;
    logic [1:0] efull;
    model_reset();
    done_cnt = 0; beat_cnt = 0; last_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rstn) model_reset();
      nt    = rows.size() / DEPTH;
      ev    = (nt > 0);
      first = (ridx == 0) && (pass == 0);
      erep  = first ? int'(rd_repeat) : rep_l;
      el    = ev && (ridx == DEPTH - 1) && (pass >= erep);
      efull = (nt == 0) ? 2'b00 : (nt >= 2) ? 2'b11 : (rbank == 1 ? 2'b10 : 2'b01);
      chk("wr_ready", wr_ready, nt < 2);
      chk("rd_valid", rd_valid, ev);
      chk("rd_data", rd_data, ev ? rows[ridx] : '0);
      chk("rd_last", rd_last, el);
      chk("bank_full", bank_full, efull);
      chk("tile_done", tile_done, done_m);
      chk("overflow", overflow, ovf_m);
      if (tile_done) done_cnt++;
      if (rd_valid && rd_ready) beat_cnt++;
      if (rd_last && rd_ready) last_cnt++;
      if (rstn) begin
        if (clear) model_reset();
        else begin
          rel = 1'b0;
          if (ev && rd_ready) begin
            if (first) rep_l = int'(rd_repeat);
            if (ridx == DEPTH - 1) begin
              ridx = 0;
              if (pass < erep) pass++;
              else begin
                for (int i = 0; i < DEPTH; i++) void'(rows.pop_front());
                rbank ^= 1;
                pass = 0;
                rel = 1'b1;
              end
            end else ridx++;
          end
          if (wr_valid) begin
            if (nt < 2) begin
              part.push_back(wr_data);
              if (part.size() == DEPTH) begin
                foreach (part[i]) rows.push_back(part[i]);
                part.delete();
              end
            end else ovf_m = 1'b1;
          end
          done_m = rel;
        end
      end
    end
  end

  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr,
                      input logic [1:0] rep, input logic clr);
    wr_valid = wv; wr_data = wd; rd_ready = rr; rd_repeat = rep; clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, '0, rr, 2'd0, 1'b0);
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom(), $urandom()};
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(2, 1'b0);

    // Single tile, rows 1..8
    done_cnt = 0; beat_cnt = 0;
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), 1'b1, 2'd0, 1'b0);
    idle(12, 1'b1);
    chk("single_done_cnt", DW'(done_cnt), DW'(1));
    chk("single_beats", DW'(beat_cnt), DW'(8));

    // Ping-pong streaming, four tiles
    done_cnt = 0;
    for (int i = 0; i < 4 * DEPTH; i++) step(1'b1, rnd(), 1'b1, 2'd0, 1'b0);
    idle(12, 1'b1);
    chk("pingpong_done_cnt", DW'(done_cnt), DW'(4));
    chk("pingpong_overflow", DW'(overflow), DW'(0));

    // Back-pressure: 17 rows with reader stalled
    done_cnt = 0;
    for (int i = 0; i < 2 * DEPTH + 1; i++) step(1'b1, rnd(), 1'b0, 2'd0, 1'b0);
    chk("bp_wr_ready", DW'(wr_ready), DW'(0));
    chk("bp_overflow", DW'(overflow), DW'(1));
    idle(20, 1'b1);
    chk("bp_done_cnt", DW'(done_cnt), DW'(2));

    // Replay: repeat=2 latched on first beat, then changed mid-tile
    for (int i = 0; i < DEPTH; i++) step(1'b1, rnd(), 1'b0, 2'd2, 1'b0);
    done_cnt = 0; beat_cnt = 0; last_cnt = 0;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 2'd2, 1'b0);
    idle(30, 1'b1);
    chk("replay_beats", DW'(beat_cnt), DW'(24));
    chk("replay_last_cnt", DW'(last_cnt), DW'(1));
    chk("replay_done_cnt", DW'(done_cnt), DW'(1));

    // clear_i on row 5 of a fill, together with a write
    for (int i = 0; i < 5; i++) step(1'b1, rnd(), 1'b0, 2'd0, 1'b0);
    step(1'b1, rnd(), 1'b0, 2'd0, 1'b1);
    chk("clear_bank_full", DW'(bank_full), DW'(0));
    chk("clear_overflow", DW'(overflow), DW'(0));
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(32'hC0 + i), 1'b1, 2'd0, 1'b0);
    idle(12, 1'b1);

    // Reset pulse while bank 1 is mid-drain
    for (int i = 0; i < DEPTH; i++) step(1'b1, rnd(), 1'b1, 2'd0, 1'b0);
    idle(4, 1'b1);
    rstn = 1'b0;
    #1;
    chk("async_rd_valid", DW'(rd_valid), DW'(0));
    chk("async_bank_full", DW'(bank_full), DW'(0));
    idle(2, 1'b1);
    rstn = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < DEPTH; i++) step(1'b1, rnd(), 1'b1, 2'd0, 1'b0);
    idle(12, 1'b1);
    chk("post_reset_done_cnt", DW'(done_cnt), DW'(1));

    // Randomized traffic with replays, stalls, overflow and occasional clears
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 9) < 7,
           2'($urandom_range(0, 3)), $urandom_range(0, 149) == 0);
    idle(40, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
